alu_req_master: RTL and testbench

Requester-side counterpart of the ALU operand/result interface: accepts operation requests on a valid/ready port, buffers them, drives `a_operand`/`b_operand`/`Operation` into the ALU one request at a time, samples `ALU_Output` and the three status flags after a fixed latency, and returns each result on a valid/ready response port. It sits between the test/control logic and the ALU and serialises traffic to it. It also keeps a saturating count of flagged results.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_req_fifo.sv | 56 +++++
 rtl/alu_req_master.sv | 110 +++++++++++
 tb/tb_alu_req_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU requester: request/flag structures and the
// sequencing FSM states used by alu_req_master.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  typedef struct packed {
    logic exc;
    logic ovf;
    logic unf;
  } alu_flags_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_op_t     op;
  } alu_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } req_state_e;

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous FIFO of ALU requests. Pushes are dropped when full and pops when
// empty. The head entry is presented combinationally.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  alu_req_t               i_wdata,
  input  logic                   i_pop,
  output alu_req_t               o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  alu_req_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/alu_req_master.sv
// Serialises buffered requests into the ALU, samples its result a fixed
// number of edges after the operand update, and returns it on a response port.
module alu_req_master
  import alu_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_op,
  output logic [31:0] a_operand,
  output logic [31:0] b_operand,
  output logic [3:0]  Operation,
  input  logic [31:0] ALU_Output,
  input  logic        Exception,
  input  logic        Overflow,
  input  logic        Underflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic [15:0] flag_count
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  req_state_e              r_state;
  logic [3:0]              r_wait_cnt;
  alu_req_t                w_wdata;
  alu_req_t                w_head;
  alu_flags_t              w_flags_in;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic [$clog2(DEPTH):0]  w_count_unused;

  assign w_wdata    = '{a: req_a, b: req_b, op: req_op};
  assign w_flags_in = '{exc: Exception, ovf: Overflow, unf: Underflow};
  assign req_ready  = !w_full;
  assign w_pop      = (r_state == IDLE) && !w_empty;

  alu_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (req_valid && req_ready),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      a_operand  <= '0;
      b_operand  <= '0;
      Operation  <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      flag_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            a_operand  <= w_head.a;
            b_operand  <= w_head.b;
            Operation  <= w_head.op;
            r_wait_cnt <= LAT_M1;
            r_state    <= WAIT;
          end
        end
        // Operands stay driven after capture; the ALU sees them until the next pop.
        WAIT: begin
          if (r_wait_cnt == '0) begin
            rsp_result <= ALU_Output;
            rsp_flags  <= w_flags_in;
            rsp_valid  <= 1'b1;
            if (w_flags_in != '0) flag_count <= sat_inc16(flag_count);
            r_state    <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_master.sv
// Bench for alu_req_master: one LATENCY=1 and one LATENCY=3 instance, each
// driving a model ALU, checked against a FIFO-ordered expected-response queue.
module tb_alu_req_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_a      [2];
  logic [31:0] req_b      [2];
  logic [3:0]  req_op     [2];
  logic [31:0] a_op       [2];
  logic [31:0] b_op       [2];
  logic [3:0]  oper       [2];
  logic [31:0] alu_out    [2];
  logic        exc        [2];
  logic        ovf        [2];
  logic        unf        [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_result [2];
  logic [2:0]  rsp_flags  [2];
  logic [15:0] flag_count [2];

  int          ncmp = 0;
  int          nfail = 0;
  logic [34:0] expq [2][$];
  logic        checked [2];
  logic [34:0] held [2];
  logic [15:0] fc_model [2];
  logic [34:0] pipe1 = '0;
  logic [34:0] pipe2 = '0;

  always #5 clk = ~clk;

  // Model ALU: result and flags as a function of operands/opcode.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    logic [31:0] r;
    if (a == 32'h3F800000 && b == 32'h40000000 && op == 4'h0) r = 32'h40400000;
    else r = (a + b) ^ {28'h0, op} ^ 32'hA5000000;
    return {op == 4'hF, op == 4'h3, op == 4'h5, r};
  endfunction

  // Instance 1's ALU only presents a fresh result two edges after its operands change.
  always_ff @(posedge clk) begin
    pipe1 <= alu_fn(a_op[1], b_op[1], oper[1]);
    pipe2 <= pipe1;
  end

  always_comb begin
    {exc[0], ovf[0], unf[0], alu_out[0]} = alu_fn(a_op[0], b_op[0], oper[0]);
    {exc[1], ovf[1], unf[1], alu_out[1]} = pipe2;
  end

  alu_req_master #(.LATENCY(1), .DEPTH(4)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_op(req_op[0]),
    .a_operand(a_op[0]), .b_operand(b_op[0]), .Operation(oper[0]),
    .ALU_Output(alu_out[0]), .Exception(exc[0]), .Overflow(ovf[0]), .Underflow(unf[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_result(rsp_result[0]), .rsp_flags(rsp_flags[0]), .flag_count(flag_count[0])
  );

  alu_req_master #(.LATENCY(3), .DEPTH(4)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_op(req_op[1]),
    .a_operand(a_op[1]), .b_operand(b_op[1]), .Operation(oper[1]),
    .ALU_Output(alu_out[1]), .Exception(exc[1]), .Overflow(ovf[1]), .Underflow(unf[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_result(rsp_result[1]), .rsp_flags(rsp_flags[1]), .flag_count(flag_count[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards every new response is matched against the queue head
  // and a held response must not change.
  task automatic tick();
    logic       hs [2];
    logic [34:0] e;
    for (int i = 0; i < 2; i++) hs[i] = rsp_valid[i] && rsp_ready[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs[i]) checked[i] = 1'b0;
      if (rst) begin
        checked[i] = 1'b0;
      end else if (rsp_valid[i]) begin
        if (!checked[i]) begin
          check($sformatf("rsp_expected[%0d]", i), 64'(expq[i].size() != 0), 64'd1);
          if (expq[i].size() != 0) begin
            e = expq[i].pop_front();
            check($sformatf("rsp_result[%0d]", i), 64'(rsp_result[i]), 64'(e[31:0]));
            check($sformatf("rsp_flags[%0d]", i), 64'(rsp_flags[i]), 64'(e[34:32]));
            if (e[34:32] != 3'b000 && fc_model[i] != 16'hFFFF) fc_model[i]++;
            check($sformatf("flag_count[%0d]", i), 64'(flag_count[i]), 64'(fc_model[i]));
            held[i] = e;
          end
          checked[i] = 1'b1;
        end else begin
          check($sformatf("rsp_stable[%0d]", i), 64'({rsp_flags[i], rsp_result[i]}),
                64'(held[i]));
        end
      end
    end
  endtask

  task automatic push(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input int budget, input bit release_rdy);
    logic acc;
    int   n;
    req_a[i] = a;
    req_b[i] = b;
    req_op[i] = op;
    req_valid[i] = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < budget) begin
      acc = req_ready[i];
      if (acc) expq[i].push_back(alu_fn(a, b, op));
      tick();
      n++;
      if (!acc && release_rdy) rsp_ready[i] = 1'b1;
    end
    req_valid[i] = 1'b0;
    check($sformatf("push_accepted[%0d]", i), 64'(acc), 64'd1);
  endtask

  task automatic drain(input int i, input int budget);
    int n;
    n = 0;
    rsp_ready[i] = 1'b1;
    while ((expq[i].size() != 0 || rsp_valid[i]) && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("drain_empty[%0d]", i), 64'(expq[i].size()), 64'd0);
    check($sformatf("drain_idle[%0d]", i), 64'(rsp_valid[i]), 64'd0);
  endtask

  task automatic check_reset(input int i);
    check($sformatf("rst_req_ready[%0d]", i), 64'(req_ready[i]), 64'd1);
    check($sformatf("rst_a_operand[%0d]", i), 64'(a_op[i]), 64'd0);
    check($sformatf("rst_b_operand[%0d]", i), 64'(b_op[i]), 64'd0);
    check($sformatf("rst_operation[%0d]", i), 64'(oper[i]), 64'd0);
    check($sformatf("rst_rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'd0);
    check($sformatf("rst_rsp_result[%0d]", i), 64'(rsp_result[i]), 64'd0);
    check($sformatf("rst_rsp_flags[%0d]", i), 64'(rsp_flags[i]), 64'd0);
    check($sformatf("rst_flag_count[%0d]", i), 64'(flag_count[i]), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  ops [3];
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_a[i] = '0;
      req_b[i] = '0;
      req_op[i] = '0;
      rsp_ready[i] = 1'b1;
      checked[i] = 1'b0;
      held[i] = '0;
      fc_model[i] = '0;
    end

    // Reset, then idle.
    repeat (3) tick();
    rst = 1'b0;
    check_reset(0);
    check_reset(1);
    repeat (2) tick();
    check("idle_req_ready", 64'(req_ready[0]), 64'd1);
    check("idle_rsp_valid", 64'(rsp_valid[0]), 64'd0);

    // Single request, LATENCY=1: operands at T1, response at T2, one-cycle pulse.
    push(0, 32'h3F800000, 32'h40000000, 4'h0, 4, 1'b0);
    tick();
    check("t1_a_operand", 64'(a_op[0]), 64'h3F800000);
    check("t1_b_operand", 64'(b_op[0]), 64'h40000000);
    check("t1_operation", 64'(oper[0]), 64'h0);
    check("t1_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    tick();
    check("t2_rsp_valid", 64'(rsp_valid[0]), 64'd1);
    check("t2_rsp_result", 64'(rsp_result[0]), 64'h40400000);
    check("t2_rsp_flags", 64'(rsp_flags[0]), 64'd0);
    check("t2_flag_count", 64'(flag_count[0]), 64'd0);
    tick();
    check("t3_rsp_pulse", 64'(rsp_valid[0]), 64'd0);
    check("t3_operand_hold", 64'(a_op[0]), 64'h3F800000);

    // Response stall with 5 requests into a 4-deep buffer.
    rsp_ready[0] = 1'b0;
    for (int k = 0; k < 5; k++)
      push(0, $urandom, $urandom, 4'($urandom_range(0, 2)), 1, 1'b0);
    check("full_req_ready", 64'(req_ready[0]), 64'd0);
    req_a[0] = $urandom;
    req_b[0] = $urandom;
    req_op[0] = 4'h1;
    req_valid[0] = 1'b1;
    repeat (2) tick();
    req_valid[0] = 1'b0;
    check("full_still_blocked", 64'(req_ready[0]), 64'd0);
    drain(0, 100);

    // Overflow on one of three operations.
    ops = '{4'h2, 4'h3, 4'h4};
    for (int k = 0; k < 3; k++) push(0, $urandom, $urandom, ops[k], 20, 1'b1);
    drain(0, 50);
    check("ovf_flag_count", 64'(flag_count[0]), 64'd1);

    // LATENCY=3: capture exactly three edges after the operand update.
    ra = $urandom | 32'h1;
    rb = $urandom | 32'h100;
    push(1, ra, rb, 4'h1, 4, 1'b0);
    tick();
    check("l3_a_operand", 64'(a_op[1]), 64'(ra));
    check("l3_b_operand", 64'(b_op[1]), 64'(rb));
    tick();
    check("l3_t2_rsp_valid", 64'(rsp_valid[1]), 64'd0);
    tick();
    check("l3_t3_rsp_valid", 64'(rsp_valid[1]), 64'd0);
    tick();
    check("l3_t4_rsp_valid", 64'(rsp_valid[1]), 64'd1);
    drain(1, 20);

    // Random traffic with random back-pressure on the LATENCY=3 instance.
    for (int k = 0; k < 10; k++) begin
      rsp_ready[1] = ($urandom_range(0, 3) != 0);
      push(1, $urandom, $urandom, 4'($urandom), 60, 1'b1);
    end
    drain(1, 200);

    // Reset while in WAIT with two requests buffered.
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    for (int k = 0; k < 3; k++) push(1, $urandom, $urandom, 4'h3, 1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expq[i].delete();
      fc_model[i] = '0;
    end
    check_reset(0);
    check_reset(1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("post_rst_no_rsp", 64'(rsp_valid[1]), 64'd0);
    end
    push(1, $urandom, $urandom, 4'($urandom_range(0, 2)), 4, 1'b0);
    drain(1, 20);
    check("post_rst_flag_count", 64'(flag_count[1]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
